// File: rtl/rf_writeback_queue.sv
// Purpose : buffers register-file writebacks, drains one per cycle on we3/wa3/wd3, flags RAW hazards on qa1/qa2.
// Latency : a write accepted at edge N into an empty queue drives we3 in the next cycle and lands at edge N+1.
// Backpress: in_ready = !full (independent of same-cycle pop); drain_en low holds the head. Option: RF_WBQ_BYPASS_EN.
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [4:0]    in_addr,
   input  logic [31:0]   in_data,
   output logic          in_ready,
   input  logic          drain_en,
   output logic          we3,
   output logic [4:0]    wa3,
   output logic [31:0]   wd3,
   input  logic [4:0]    qa1,
   input  logic [4:0]    qa2,
   output logic          pend1,
   output logic          pend2,
   output logic [31:0]   fwd1_data,
   output logic [31:0]   fwd2_data,
   output logic [PW:0]   count,
   output logic          empty,
   output logic          full
);

   // One queued writeback: destination register and the value destined for it.
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wbq_entry_t;

   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

   wbq_entry_t        entry_q [DEPTH];
   logic [DEPTH-1:0]  entry_vld;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;

   logic              push_fire;
   logic              push_store;
   logic              pop_fire;

   assign full       = (count == DEPTH_CNT);
   assign empty      = (count == '0);
   assign in_ready   = !full;

   // Register 0 is hardwired: such requests are handshaked but never stored.
   assign push_fire  = in_valid && in_ready;
   assign push_store = push_fire && (in_addr != 5'd0);

   // The head retires on the same edge that the register file captures it.
   assign pop_fire   = !empty && drain_en;
   assign we3        = pop_fire;

   // Present the head entry on the write port; zero when nothing is queued.
   always_comb begin
      wa3 = 5'd0;
      wd3 = 32'd0;
      if (!empty) begin
         wa3 = entry_q[head].addr;
         wd3 = entry_q[head].data;
      end
   end

   // Pointer, occupancy and valid-bit bookkeeping; reset discards everything pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         entry_vld <= '0;
      end else begin
         if (pop_fire) begin
            head            <= head + 1'b1;
            entry_vld[head] <= 1'b0;
         end
         // A push and a pop never share a slot: that needs head==tail, i.e. empty (no pop) or full (no push).
         if (push_store) begin
            tail            <= tail + 1'b1;
            entry_vld[tail] <= 1'b1;
         end
         case ({push_store, pop_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage; contents are only observed through valid bits, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_store) begin
         entry_q[tail] <= '{addr: in_addr, data: in_data};
      end
   end

   // Hazard scan from oldest to youngest so the last match seen is the youngest write.
   always_comb begin
      logic [PW-1:0] idx;
      idx       = head;
      pend1     = 1'b0;
      pend2     = 1'b0;
      fwd1_data = 32'd0;
      fwd2_data = 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (entry_vld[idx] && (qa1 != 5'd0) && (entry_q[idx].addr == qa1)) begin
            pend1 = 1'b1;
`ifdef RF_WBQ_BYPASS_EN
            fwd1_data = entry_q[idx].data;
`endif
         end
         if (entry_vld[idx] && (qa2 != 5'd0) && (entry_q[idx].addr == qa2)) begin
            pend2 = 1'b1;
`ifdef RF_WBQ_BYPASS_EN
            fwd2_data = entry_q[idx].data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Purpose : directed and randomized check of rf_writeback_queue against a queue-based reference model.
// Latency : model advances on each rising edge; outputs are sampled 1ns after the driving (falling) edge.
// Backpress: model accepts only when fewer than DEPTH entries are held and retires only when drain_en is set.
module tb_rf_writeback_queue;

   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [4:0]    in_addr;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          drain_en;
   logic          we3;
   logic [4:0]    wa3;
   logic [31:0]   wd3;
   logic [4:0]    qa1;
   logic [4:0]    qa2;
   logic          pend1;
   logic          pend2;
   logic [31:0]   fwd1_data;
   logic [31:0]   fwd2_data;
   logic [PW:0]   count;
   logic          empty;
   logic          full;

   always #5 clk = ~clk;

   rf_writeback_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .drain_en  (drain_en),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .qa1       (qa1),
      .qa2       (qa2),
      .pend1     (pend1),
      .pend2     (pend2),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   wb_t model_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
      end
   endtask

   // Youngest pending write to qa as {hit, data}; register 0 never counts.
   function automatic logic [32:0] youngest(input logic [4:0] qa);
      if (qa == 5'd0) return 33'd0;
      for (int i = model_q.size() - 1; i >= 0; i--) begin
         if (model_q[i].a == qa) return {1'b1, model_q[i].d};
      end
      return 33'd0;
   endfunction

   task automatic check_outputs(input string pfx);
      logic        e_empty;
      logic [32:0] h1;
      logic [32:0] h2;
      logic [31:0] e_f1;
      logic [31:0] e_f2;
      e_empty = (model_q.size() == 0);
      h1      = youngest(qa1);
      h2      = youngest(qa2);
`ifdef RF_WBQ_BYPASS_EN
      e_f1 = h1[32] ? h1[31:0] : 32'd0;
      e_f2 = h2[32] ? h2[31:0] : 32'd0;
`else
      e_f1 = 32'd0;
      e_f2 = 32'd0;
`endif
      check({pfx, ".count"},    32'(count),    32'(model_q.size()));
      check({pfx, ".empty"},    32'(empty),    32'(e_empty));
      check({pfx, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
      check({pfx, ".in_ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
      check({pfx, ".we3"},      32'(we3),      32'(!e_empty && drain_en));
      check({pfx, ".wa3"},      32'(wa3),      e_empty ? 32'd0 : 32'(model_q[0].a));
      check({pfx, ".wd3"},      wd3,           e_empty ? 32'd0 : model_q[0].d);
      check({pfx, ".pend1"},    32'(pend1),    32'(h1[32]));
      check({pfx, ".pend2"},    32'(pend2),    32'(h2[32]));
      check({pfx, ".fwd1"},     fwd1_data,     e_f1);
      check({pfx, ".fwd2"},     fwd2_data,     e_f2);
   endtask

   // Drive one cycle on the falling edge, compare, then advance the model on the rising edge.
   task automatic run_cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic de, input logic [4:0] q1, input logic [4:0] q2);
      logic do_push;
      logic do_pop;
      @(negedge clk);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      drain_en = de;
      qa1      = q1;
      qa2      = q2;
      #1;
      check_outputs("cyc");
      do_pop  = (model_q.size() != 0) && de;
      do_push = v && (model_q.size() < DEPTH) && (a != 5'd0);
      @(posedge clk);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{a: a, d: d});
   endtask

   // Assert reset asynchronously in the high phase, then release it in the low phase.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_q.delete();
      #1;
      check_outputs("rst");
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_addr  = 5'd0;
      in_data  = 32'd0;
      drain_en = 1'b0;
      qa1      = 5'd0;
      qa2      = 5'd0;
      #1;
      check_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Single write: visible on the port one cycle after acceptance, then gone.
      run_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp1.we3", 32'(we3), 32'd1);
      check("tp1.wa3", 32'(wa3), 32'd5);
      check("tp1.wd3", wd3, 32'hDEADBEEF);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp1.empty", 32'(empty), 32'd1);
      check("tp1.we3_off", 32'(we3), 32'd0);

      // Fill with drain held off, then drain in order.
      for (int i = 1; i <= 4; i++) run_cycle(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 5'd0);
      #1;
      check("tp2.full", 32'(full), 32'd1);
      check("tp2.in_ready", 32'(in_ready), 32'd0);
      check("tp2.count", 32'(count), 32'd4);
      for (int i = 1; i <= 4; i++) run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp2.empty", 32'(empty), 32'd1);

      // Register 0 is accepted but never stored.
      run_cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp3.count", 32'(count), 32'd0);
      check("tp3.in_ready", 32'(in_ready), 32'd1);
      check("tp3.we3", 32'(we3), 32'd0);

      // Two writes to the same register: hazard flagged, youngest data forwarded.
      run_cycle(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
      run_cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
      #1;
      check("tp4.pend1", 32'(pend1), 32'd1);
      check("tp4.pend2", 32'(pend2), 32'd0);
`ifdef RF_WBQ_BYPASS_EN
      check("tp4.fwd1", fwd1_data, 32'h22);
`else
      check("tp4.fwd1", fwd1_data, 32'd0);
`endif
      run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);

      // Full with a pop: no push that cycle, then push and pop together.
      for (int i = 1; i <= 4; i++) run_cycle(1'b1, 5'(i + 10), 32'(i), 1'b0, 5'd0, 5'd0);
      run_cycle(1'b1, 5'd9, 32'hAA, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp5.count_pop", 32'(count), 32'd3);
      run_cycle(1'b1, 5'd10, 32'hBB, 1'b1, 5'd0, 5'd0);
      #1;
      check("tp5.count_both", 32'(count), 32'd3);

      // Asynchronous reset with three entries pending; nothing is written afterwards.
      do_reset();
      check("tp6.we3", 32'(we3), 32'd0);
      check("tp6.count", 32'(count), 32'd0);
      check("tp6.empty", 32'(empty), 32'd1);
      repeat (3) run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

      // Randomized traffic over a small address range to provoke hazards and aliasing.
      for (int n = 0; n < 2000; n++) begin
         run_cycle($urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)),
                   32'($urandom),
                   $urandom_range(0, 9) < 6,
                   5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)));
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
